// File: rtl/msx_slot_initiator.sv
// msx_slot_initiator
// Host-side initiator for the MSX cartridge slot bus. A single-word request
// (read/write, 15-bit address, 8-bit data) is turned into a timed memory
// cycle: SETUP -> STROBE (stretched by slot_nwait) -> HOLD -> GAP -> IDLE.
// Every slot pin comes straight from a flop. Reset is asynchronous, so the
// strobes and selects release as soon as reset is asserted, without a clock.

module msx_slot_initiator #(
  parameter int unsigned SETUP_CLKS  = 3,   // 1..15
  parameter int unsigned STROBE_CLKS = 9,   // 2..15
  parameter int unsigned HOLD_CLKS   = 3,   // 1..15
  parameter int unsigned GAP_CLKS    = 3,   // 1..15
  parameter int unsigned WAIT_MAX    = 255  // 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [14:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [14:0] slot_a,
  inout  wire  [7:0]  slot_d,
  output logic        slot_nsltsl,
  output logic        slot_nmerq,
  output logic        slot_nrd,
  output logic        slot_nwr,
  input  logic        slot_nwait
);

  // Last value of each phase counter. The counters start at 0 on phase
  // entry and are compared for equality, so they never wrap.
  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CLKS - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CLKS - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CLKS - 1);
  localparam logic [3:0] GAP_LAST    = 4'(GAP_CLKS - 1);
  localparam logic [7:0] WAIT_LIMIT  = 8'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  phase_q, phase_d;     // clocks spent in the current phase
  logic [7:0]  wait_q, wait_d;       // strobe-extension clocks so far
  logic        extend_q, extend_d;   // base strobe done, stretching on nwait
  logic        we_q, we_d;           // direction of the latched request
  logic        timeout_q, timeout_d; // current cycle was aborted
  logic        nwait_meta_q;         // first synchronizer stage
  logic        nwait_sync_q;         // synchronized slot_nwait

  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [14:0] slot_a_q, slot_a_d;
  logic        sel_q, sel_d;         // shared by nsltsl and nmerq
  logic        nrd_q, nrd_d;
  logic        nwr_q, nwr_d;
  logic [7:0]  dout_q, dout_d;
  logic        doe_q, doe_d;

  logic        start;
  logic        release_strobe;
  logic        timeout_hit;

  // Next-state and next-output logic for the whole bus cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    state_d        = state_q;
    phase_d        = phase_q;
    wait_d         = wait_q;
    extend_d       = extend_q;
    we_d           = we_q;
    timeout_d      = timeout_q;
    busy_d         = busy_q;
    ack_d          = 1'b0;
    err_d          = err_q;
    rdata_d        = rdata_q;
    slot_a_d       = slot_a_q;
    sel_d          = sel_q;
    nrd_d          = nrd_q;
    nwr_d          = nwr_q;
    dout_d         = dout_q;
    doe_d          = doe_q;
    start          = 1'b0;
    release_strobe = 1'b0;
    timeout_hit    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        start = req;
      end

      S_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          state_d = S_STROBE;
          phase_d = '0;
          nrd_d   = we_q;
          nwr_d   = ~we_q;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end

      S_STROBE: begin
        if (!extend_q) begin
          if (phase_q == STROBE_LAST) begin
            // Only the synced nwait seen on the final base clock matters.
            if (nwait_sync_q) begin
              release_strobe = 1'b1;
            end else begin
              extend_d = 1'b1;
              wait_d   = 8'd1;
            end
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end else if (nwait_sync_q) begin
          release_strobe = 1'b1;
        end else if (wait_q == WAIT_LIMIT) begin
          release_strobe = 1'b1;
          timeout_hit    = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_HOLD: begin
        if (phase_q == HOLD_LAST) begin
          state_d = S_GAP;
          phase_d = '0;
          sel_d   = 1'b1;
          doe_d   = 1'b0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end

      S_GAP: begin
        if (phase_q == GAP_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          err_d   = timeout_q;
          // A request present on the completion edge chains straight into
          // the next cycle, so back-to-back cycles see exactly GAP_CLKS idle.
          start   = req;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (release_strobe) begin
      state_d   = S_HOLD;
      phase_d   = '0;
      extend_d  = 1'b0;
      nrd_d     = 1'b1;
      nwr_d     = 1'b1;
      timeout_d = timeout_hit;
      // Read data is taken while the strobe is still low on this edge.
      if (!we_q && !timeout_hit) begin
        rdata_d = slot_d;
      end
    end

    if (start) begin
      state_d   = S_SETUP;
      phase_d   = '0;
      wait_d    = '0;
      extend_d  = 1'b0;
      timeout_d = 1'b0;
      we_d      = we;
      slot_a_d  = addr;
      dout_d    = wdata;
      doe_d     = we;
      sel_d     = 1'b0;
      busy_d    = 1'b1;
    end
  end

  // State, outputs and the nwait synchronizer, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every flop here is a small control or data register, so all
      // get a reset value; the pins must read idle the instant reset rises.
      state_q      <= S_IDLE;
      phase_q      <= '0;
      wait_q       <= '0;
      extend_q     <= 1'b0;
      we_q         <= 1'b0;
      timeout_q    <= 1'b0;
      nwait_meta_q <= 1'b1;
      nwait_sync_q <= 1'b1;
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      slot_a_q     <= '0;
      sel_q        <= 1'b1;
      nrd_q        <= 1'b1;
      nwr_q        <= 1'b1;
      dout_q       <= '0;
      doe_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      phase_q      <= phase_d;
      wait_q       <= wait_d;
      extend_q     <= extend_d;
      we_q         <= we_d;
      timeout_q    <= timeout_d;
      nwait_meta_q <= slot_nwait;
      nwait_sync_q <= nwait_meta_q;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      slot_a_q     <= slot_a_d;
      sel_q        <= sel_d;
      nrd_q        <= nrd_d;
      nwr_q        <= nwr_d;
      dout_q       <= dout_d;
      doe_q        <= doe_d;
    end
  end

  assign busy        = busy_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign slot_a      = slot_a_q;
  assign slot_nsltsl = sel_q;
  assign slot_nmerq  = sel_q;
  assign slot_nrd    = nrd_q;
  assign slot_nwr    = nwr_q;
  assign slot_d      = doe_q ? dout_q : 8'bz;

endmodule

// File: tb/tb_msx_slot_initiator.sv
// Testbench for msx_slot_initiator. A cartridge model answers reads on
// slot_d; pull-ups make an undriven bus read as 8'hFF. Each transaction's
// expected pin timeline is derived from the phase lengths and the nwait
// pattern (seen through a two-clock synchronizer delay), then compared
// clock by clock against the DUT.

module tb_msx_slot_initiator;

  localparam int SETUP  = 3;
  localparam int STROBE = 9;
  localparam int HOLD   = 3;
  localparam int GAP    = 3;
  localparam int WM     = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [14:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        ack;
  logic        err;
  logic [7:0]  rdata;
  logic [14:0] slot_a;
  wire  [7:0]  slot_d;
  logic        slot_nsltsl;
  logic        slot_nmerq;
  logic        slot_nrd;
  logic        slot_nwr;
  logic        slot_nwait;
  logic [7:0]  cart_data;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_rdata;
  logic        exp_err;

  msx_slot_initiator #(
    .SETUP_CLKS (SETUP),
    .STROBE_CLKS(STROBE),
    .HOLD_CLKS  (HOLD),
    .GAP_CLKS   (GAP),
    .WAIT_MAX   (WM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .slot_a     (slot_a),
    .slot_d     (slot_d),
    .slot_nsltsl(slot_nsltsl),
    .slot_nmerq (slot_nmerq),
    .slot_nrd   (slot_nrd),
    .slot_nwr   (slot_nwr),
    .slot_nwait (slot_nwait)
  );

  always #5 clk = ~clk;

  // Cartridge: drives read data while selected and read-strobed.
  assign slot_d = (!slot_nrd && !slot_nsltsl) ? cart_data : 8'bz;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (slot_d[i]);
  end

  // nwait level driven during period p (period 1 follows the accept edge).
  function automatic bit nw_level(input int p, input int ns, input int nl);
    return !(nl > 0 && p >= ns && p < ns + nl);
  endfunction

  // One transaction, called between edges; the next posedge accepts it.
  task automatic run_txn(input bit t_we, input logic [14:0] t_addr,
                         input logic [7:0] t_wdata, input logic [7:0] t_cart,
                         input int ns, input int nl,
                         input bit chained_in, input bit hold_req,
                         input bit noise);
    int         q;
    int         ext;
    int         ack_p;
    int         last;
    bit         done;
    bit         m_err;
    bit         strobe;
    logic [7:0] m_rdata;
    logic [7:0] exp_d;
    logic [7:0] exp_rd;
    logic       exp_e;
    logic [5:0] ctl;
    logic [5:0] exp_ctl;

    // Strobe ends at the close of period q; extension decisions use the
    // nwait level from two periods earlier.
    q     = SETUP + STROBE;
    ext   = 0;
    m_err = 1'b0;
    done  = nw_level(q - 2, ns, nl);
    while (!done) begin
      q++;
      ext++;
      if (nw_level(q - 2, ns, nl)) begin
        done = 1'b1;
      end else if (ext == WM) begin
        m_err = 1'b1;
        done  = 1'b1;
      end
    end
    ack_p   = q + HOLD + GAP + 1;
    m_rdata = (!t_we && !m_err) ? t_cart : exp_rdata;
    last    = hold_req ? ack_p - 1 : ack_p;

    req       = 1'b1;
    we        = t_we;
    addr      = t_addr;
    wdata     = t_wdata;
    cart_data = t_cart;

    for (int p = 1; p <= last; p++) begin
      @(posedge clk);
      #1;
      slot_nwait = nw_level(p, ns, nl);
      if (!hold_req) begin
        if (noise && p < ack_p - 1) begin
          req   = 1'($urandom_range(0, 1));
          we    = 1'($urandom_range(0, 1));
          addr  = 15'($urandom);
          wdata = 8'($urandom);
        end else begin
          req = 1'b0;
        end
      end
      @(negedge clk);

      strobe  = (p > SETUP) && (p <= q);
      exp_ctl = {p > q + HOLD, p > q + HOLD, !(strobe && !t_we),
                 !(strobe && t_we), p < ack_p,
                 (p == ack_p) || (p == 1 && chained_in)};
      ctl     = {slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr, busy, ack};
      tests++;
      if (ctl !== exp_ctl) begin
        fails++;
        $display("FAIL ctl p=%0d {nsltsl,nmerq,nrd,nwr,busy,ack} got %b want %b", p, ctl, exp_ctl);
      end

      if (p <= q + HOLD) begin
        tests++;
        if (slot_a !== t_addr) begin
          fails++;
          $display("FAIL slot_a p=%0d got %h want %h", p, slot_a, t_addr);
        end
      end

      if (t_we) exp_d = (p <= q + HOLD) ? t_wdata : 8'hFF;
      else      exp_d = strobe ? t_cart : 8'hFF;
      tests++;
      if (slot_d !== exp_d) begin
        fails++;
        $display("FAIL slot_d p=%0d we=%0b got %h want %h", p, t_we, slot_d, exp_d);
      end

      exp_rd = (p > q) ? m_rdata : exp_rdata;
      tests++;
      if (rdata !== exp_rd) begin
        fails++;
        $display("FAIL rdata p=%0d got %h want %h", p, rdata, exp_rd);
      end

      exp_e = (p >= ack_p) ? m_err : exp_err;
      tests++;
      if (err !== exp_e) begin
        fails++;
        $display("FAIL err p=%0d got %b want %b", p, err, exp_e);
      end
    end

    exp_rdata  = m_rdata;
    exp_err    = m_err;
    slot_nwait = 1'b1;
    req        = hold_req;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req        = 1'b0;
    we         = 1'b0;
    addr       = '0;
    wdata      = '0;
    cart_data  = '0;
    slot_nwait = 1'b1;
    #12;
    tests++;
    if ({slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr, busy, ack, err} !== 7'b1111000) begin
      fails++;
      $display("FAIL reset_ctl got %b want 1111000", {slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr, busy, ack, err});
    end
    tests++;
    if (rdata !== 8'h00 || slot_a !== 15'h0000 || slot_d !== 8'hFF) begin
      fails++;
      $display("FAIL reset_data rdata=%h slot_a=%h slot_d=%h want 00/0000/FF", rdata, slot_a, slot_d);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_rdata = 8'h00;
    exp_err   = 1'b0;
  endtask

  task automatic test_read_basic();
    run_txn(1'b0, 15'h5000, 8'h00, 8'hA5, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_write_basic();
    run_txn(1'b1, 15'h7FFF, 8'h3C, 8'h11, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // nwait low for 20 clocks from the 4th strobe clock.
  task automatic test_wait_extend();
    run_txn(1'b0, 15'h1234, 8'h00, 8'h96, SETUP + 4, 20, 1'b0, 1'b0, 1'b0);
  endtask

  // nwait stuck low: abort with err, then a normal read clears err.
  task automatic test_timeout();
    run_txn(1'b0, 15'h2AAA, 8'h00, 8'hC3, SETUP + 1, 80, 1'b0, 1'b0, 1'b0);
    run_txn(1'b0, 15'h2AAB, 8'h00, 8'h5E, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // req held high across three reads; extra requests while busy are dropped.
  task automatic test_back_to_back();
    run_txn(1'b0, 15'h0100, 8'h00, 8'h01, 0, 0, 1'b0, 1'b1, 1'b0);
    run_txn(1'b0, 15'h0200, 8'h00, 8'h02, 0, 0, 1'b1, 1'b1, 1'b0);
    run_txn(1'b0, 15'h0300, 8'h00, 8'h03, 0, 0, 1'b1, 1'b0, 1'b0);
    run_txn(1'b1, 15'h0400, 8'h44, 8'h00, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  // Reset in the middle of a write strobe releases the bus without a clock.
  task automatic test_reset_mid();
    req   = 1'b1;
    we    = 1'b1;
    addr  = 15'h3456;
    wdata = 8'h5A;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    tests++;
    if (slot_nwr !== 1'b0 || slot_d !== 8'h5A) begin
      fails++;
      $display("FAIL mid_strobe nwr=%b slot_d=%h want 0/5A", slot_nwr, slot_d);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr, busy, ack} !== 6'b111100 || slot_d !== 8'hFF) begin
      fails++;
      $display("FAIL async_reset ctl=%b slot_d=%h want 111100/FF", {slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr, busy, ack}, slot_d);
    end
    @(posedge clk);
    #1;
    tests++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold ack=%b busy=%b want 0/0", ack, busy);
    end
    @(negedge clk);
    reset     = 1'b0;
    exp_rdata = 8'h00;
    exp_err   = 1'b0;
    @(negedge clk);
    tests++;
    if (rdata !== 8'h00 || err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset rdata=%h err=%b busy=%b want 00/0/0", rdata, err, busy);
    end
    run_txn(1'b0, 15'h4321, 8'h00, 8'h7E, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit chained;
    bit hold;
    int ns;
    int nl;
    chained = 1'b0;
    for (int i = 0; i < 40; i++) begin
      hold = (i < 39) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        ns = 0;
        nl = 0;
      end else begin
        ns = $urandom_range(4, 14);
        nl = $urandom_range(1, 40);
      end
      run_txn(1'($urandom_range(0, 1)), 15'($urandom), 8'($urandom), 8'($urandom),
              ns, nl, chained, hold, !hold && ($urandom_range(0, 1) == 1));
      chained = hold;
      if (!hold) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_wait_extend();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
